// File: rtl/tetris_input_pkg.sv
// Shared definitions for the Tetris keyboard input path.
// Contents:
//   - PS/2 set-2 scan-code constants (prefixes and the mapped keys)
//   - key_e: index of each game key in the held/pending/output vectors
//   - parser_state_e: states of the scan-code parser
//   - map_key(): scan-code plus extended flag to {valid, key index}
package tetris_input_pkg;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_LEFT   = 8'h6B;
    localparam logic [7:0] SC_RIGHT  = 8'h74;
    localparam logic [7:0] SC_DOWN   = 8'h72;
    localparam logic [7:0] SC_ROTATE = 8'h75;
    localparam logic [7:0] SC_DROP   = 8'h29;

    localparam int unsigned NUM_KEYS      = 5;
    // Auto-repeat only exists for the first three indices (left, right, down).
    localparam int unsigned NUM_MOVE_KEYS = 3;

    typedef enum logic [2:0] {
        KEY_LEFT   = 3'd0,
        KEY_RIGHT  = 3'd1,
        KEY_DOWN   = 3'd2,
        KEY_ROTATE = 3'd3,
        KEY_DROP   = 3'd4
    } key_e;

    typedef enum logic [1:0] {
        StIdle,
        StExt,
        StBrk,
        StExtBrk
    } parser_state_e;

    typedef struct packed {
        logic valid;
        key_e key;
    } key_map_t;

    // Movement/rotate keys live on the extended page, drop (space) does not.
    function automatic key_map_t map_key(input logic [7:0] sc, input logic ext);
        key_map_t m;
        m.valid = 1'b0;
        m.key   = KEY_LEFT;
        if (ext) begin
            case (sc)
                SC_LEFT:   begin m.valid = 1'b1; m.key = KEY_LEFT;   end
                SC_RIGHT:  begin m.valid = 1'b1; m.key = KEY_RIGHT;  end
                SC_DOWN:   begin m.valid = 1'b1; m.key = KEY_DOWN;   end
                SC_ROTATE: begin m.valid = 1'b1; m.key = KEY_ROTATE; end
                default:   m.valid = 1'b0;
            endcase
        end else if (sc == SC_DROP) begin
            m.valid = 1'b1;
            m.key   = KEY_DROP;
        end
        return m;
    endfunction

endpackage

// File: rtl/ps2_code_parser.sv
// PS/2 scan-code parser: folds E0/F0 prefixes into make/break events.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   code_valid   one-cycle strobe qualifying code
//   code         scan-code byte
//   make         one-cycle strobe: mapped key pressed
//   brk          one-cycle strobe: mapped key released
//   key          key index qualified by make/brk
// Unmapped codes produce no strobe. Events appear one cycle after the final byte.
module ps2_code_parser
    import tetris_input_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       code_valid,
    input  logic [7:0] code,
    output logic       make,
    output logic       brk,
    output key_e       key
);

    parser_state_e state;
    key_map_t      plain_map;
    key_map_t      ext_map;

    assign plain_map = map_key(code, 1'b0);
    assign ext_map   = map_key(code, 1'b1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= StIdle;
            make  <= 1'b0;
            brk   <= 1'b0;
            key   <= KEY_LEFT;
        end else begin
            make <= 1'b0;
            brk  <= 1'b0;
            if (code_valid) begin
                unique case (state)
                    StIdle: begin
                        if (code == SC_EXT) begin
                            state <= StExt;
                        end else if (code == SC_BRK) begin
                            state <= StBrk;
                        end else begin
                            make <= plain_map.valid;
                            key  <= plain_map.key;
                        end
                    end
                    StExt: begin
                        if (code == SC_BRK) begin
                            state <= StExtBrk;
                        end else if (code != SC_EXT) begin
                            // A repeated E0 simply keeps us on the extended page.
                            make  <= ext_map.valid;
                            key   <= ext_map.key;
                            state <= StIdle;
                        end
                    end
                    StBrk: begin
                        brk   <= plain_map.valid;
                        key   <= plain_map.key;
                        state <= StIdle;
                    end
                    StExtBrk: begin
                        brk   <= ext_map.valid;
                        key   <= ext_map.key;
                        state <= StIdle;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/tetris_input_ctrl.sv
// Game-core input producer: scan-code stream to tick strobe and key levels.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   code_valid, code           scan-code byte stream from the PS/2 receiver
//   game_over                  forces all key outputs low while set
//   tick_game                  one-cycle game tick
//   key_left/right/down        movement keys, high only in the tick cycle
//   key_rotate/drop            rotate / hard drop, high only in the tick cycle
// Presses are latched until the next tick; held movement keys auto-repeat
// after DAS_TICKS and then every ARR_TICKS ticks.
module tetris_input_ctrl
    import tetris_input_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 1666667,
    parameter int unsigned DAS_TICKS = 10,
    parameter int unsigned ARR_TICKS = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       code_valid,
    input  logic [7:0] code,
    input  logic       game_over,
    output logic       tick_game,
    output logic       key_left,
    output logic       key_right,
    output logic       key_down,
    output logic       key_rotate,
    output logic       key_drop
);

    localparam int unsigned   CntW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CntW-1:0] TickLast = CntW'(TICK_DIV - 1);
    localparam logic [7:0]    DasTicks = 8'(DAS_TICKS);
    localparam logic [7:0]    ArrTicks = 8'(ARR_TICKS);

    logic                     make_stb;
    logic                     brk_stb;
    key_e                     key_idx;

    logic [CntW-1:0]          tick_cnt_q;
    logic                     tick_edge;
    logic                     tick_q;
    logic [NUM_KEYS-1:0]      held_q, held_d;
    logic [NUM_KEYS-1:0]      pending_q, pending_d;
    logic [NUM_KEYS-1:0]      keys_q, keys_d;
    logic [NUM_MOVE_KEYS-1:0] armed_q, armed_d;
    logic [7:0]               rpt_cnt_q [NUM_MOVE_KEYS];
    logic [7:0]               rpt_cnt_d [NUM_MOVE_KEYS];
    logic [NUM_KEYS-1:0]      fire;
    logic [NUM_KEYS-1:0]      emit;
    logic [7:0]               rpt_next;

    ps2_code_parser u_parser (
        .clk        (clk),
        .rst_n      (rst_n),
        .code_valid (code_valid),
        .code       (code),
        .make       (make_stb),
        .brk        (brk_stb),
        .key        (key_idx)
    );

    assign tick_edge = (tick_cnt_q == TickLast);

    always_comb begin
        held_d    = held_q;
        pending_d = pending_q;
        armed_d   = armed_q;
        rpt_cnt_d = rpt_cnt_q;
        keys_d    = '0;
        fire      = '0;
        emit      = '0;
        rpt_next  = '0;

        if (tick_edge) begin
            for (int k = 0; k < NUM_MOVE_KEYS; k++) begin
                rpt_next = rpt_cnt_q[k] + 8'd1;
                if (held_q[k]) begin
                    if (pending_q[k]) begin
                        // First emission restarts the delay phase.
                        rpt_cnt_d[k] = '0;
                        armed_d[k]   = 1'b0;
                    end else if (rpt_next == (armed_q[k] ? ArrTicks : DasTicks)) begin
                        fire[k]      = 1'b1;
                        rpt_cnt_d[k] = '0;
                        armed_d[k]   = 1'b1;
                    end else begin
                        rpt_cnt_d[k] = rpt_next;
                    end
                end
            end
            emit = pending_q | fire;
            if (emit[KEY_LEFT] && emit[KEY_RIGHT]) begin
                emit[KEY_LEFT]  = 1'b0;
                emit[KEY_RIGHT] = 1'b0;
            end
            keys_d    = game_over ? '0 : emit;
            pending_d = '0;
        end

        // Parser events apply after the tick so a make on the tick edge survives
        // into the next tick; all decisions above used pre-edge state.
        for (int k = 0; k < NUM_KEYS; k++) begin
            if (int'(key_idx) == k) begin
                if (make_stb && !held_q[k]) begin
                    held_d[k]    = 1'b1;
                    pending_d[k] = 1'b1;
                end
                if (brk_stb) begin
                    held_d[k] = 1'b0;
                end
            end
        end
        for (int k = 0; k < NUM_MOVE_KEYS; k++) begin
            if (brk_stb && int'(key_idx) == k) begin
                armed_d[k]   = 1'b0;
                rpt_cnt_d[k] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_q <= '0;
            tick_q     <= 1'b0;
            held_q     <= '0;
            pending_q  <= '0;
            keys_q     <= '0;
            armed_q    <= '0;
            for (int k = 0; k < NUM_MOVE_KEYS; k++) begin
                rpt_cnt_q[k] <= '0;
            end
        end else begin
            tick_cnt_q <= tick_edge ? '0 : tick_cnt_q + 1'b1;
            tick_q     <= tick_edge;
            held_q     <= held_d;
            pending_q  <= pending_d;
            keys_q     <= keys_d;
            armed_q    <= armed_d;
            rpt_cnt_q  <= rpt_cnt_d;
        end
    end

    assign tick_game  = tick_q;
    assign key_left   = keys_q[KEY_LEFT];
    assign key_right  = keys_q[KEY_RIGHT];
    assign key_down   = keys_q[KEY_DOWN];
    assign key_rotate = keys_q[KEY_ROTATE];
    assign key_drop   = keys_q[KEY_DROP];

endmodule
